// File: rtl/port_bank_pkg.sv
// Shared definitions for the motorised port bank: per-port state encoding and
// the open-request arbitration used by the airlock interlock.
package port_bank_pkg;

  // Widest bank supported; arbitration works on vectors of this width.
  localparam int MAX_PORTS = 8;

  typedef enum logic [1:0] {
    ST_CLOSED  = 2'd0,
    ST_OPENING = 2'd1,
    ST_OPEN    = 2'd2,
    ST_CLOSING = 2'd3
  } port_state_e;

  // Decide which open requests may start travelling this cycle.
  // open_req: request bits from ports that are currently CLOSED.
  // closed:   CLOSED status of every port (unused positions must read 1).
  // With the interlock on, an open is only allowed when the whole bank is
  // closed, and then only the lowest-index requester wins.
  function automatic logic [MAX_PORTS-1:0] grant_open(
    input logic [MAX_PORTS-1:0] open_req,
    input logic [MAX_PORTS-1:0] closed,
    input logic                 interlock
  );
    logic [MAX_PORTS-1:0] grant;
    logic                 found;
    grant = '0;
    found = 1'b0;
    if (!interlock) begin
      grant = open_req;
    end else if (&closed) begin
      for (int i = 0; i < MAX_PORTS; i++) begin
        if (open_req[i] && !found) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/port_channel.sv
// One motorised port: switch edge detect, CLOSED/OPENING/OPEN/CLOSING FSM,
// travel counter and state-decoded status outputs. The open grant comes from
// the bank-level arbiter; closing and reversal never need a grant.
module port_channel
  import port_bank_pkg::*;
#(
  parameter int TRAVEL_CYCLES = 4,
  parameter int CNT_W         = 2
) (
  input  logic clk,
  input  logic srst,
  input  logic flip,
  input  logic grant,
  output logic req,
  output logic is_closed,
  output logic open_state,
  output logic moving,
  output logic denied
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TRAVEL_CYCLES - 1);

  logic        sw_q_reg;
  logic        sw_q2_reg;
  port_state_e state_reg;
  port_state_e state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic        denied_reg;
  logic        denied_next;

  // Two-stage switch sampling; a request is the first cycle the switch reads high.
  always_ff @(posedge clk) begin
    if (srst) begin
      sw_q_reg  <= 1'b0;
      sw_q2_reg <= 1'b0;
    end else begin
      sw_q_reg  <= flip;
      sw_q2_reg <= sw_q_reg;
    end
  end

  assign req = sw_q_reg & ~sw_q2_reg;

  // State, travel counter and the registered deny pulse.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg  <= ST_CLOSED;
      cnt_reg    <= '0;
      denied_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      denied_reg <= denied_next;
    end
  end

  // Next-state logic; a request mid-travel reverses and mirrors the counter so
  // the way back takes as long as the travel already done.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    denied_next = 1'b0;
    case (state_reg)
      ST_CLOSED: begin
        if (req) begin
          if (grant) begin
            state_next = ST_OPENING;
            cnt_next   = '0;
          end else begin
            denied_next = 1'b1;
          end
        end
      end
      ST_OPENING: begin
        if (req) begin
          state_next = ST_CLOSING;
          cnt_next   = CNT_LAST - cnt_reg;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = ST_OPEN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_OPEN: begin
        if (req) begin
          state_next = ST_CLOSING;
          cnt_next   = '0;
        end
      end
      ST_CLOSING: begin
        if (req) begin
          state_next = ST_OPENING;
          cnt_next   = CNT_LAST - cnt_reg;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = ST_CLOSED;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = ST_CLOSED;
        cnt_next   = '0;
      end
    endcase
  end

  // Status outputs decoded purely from registers, so they cannot glitch.
  always_comb begin
    is_closed  = (state_reg == ST_CLOSED);
    open_state = (state_reg == ST_OPEN);
    moving     = (state_reg == ST_OPENING) || (state_reg == ST_CLOSING);
    denied     = denied_reg;
  end

endmodule

// File: rtl/port_bank_ctrl.sv
// Bank of NUM_PORTS motorised ports. Each port runs its own channel; this level
// only arbitrates open requests against the airlock interlock and forms Busy.
module port_bank_ctrl
  import port_bank_pkg::*;
#(
  parameter int NUM_PORTS     = 2,
  parameter int TRAVEL_CYCLES = 4,
  parameter int INTERLOCK     = 1
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [NUM_PORTS-1:0] SwitchFlip,
  output logic [NUM_PORTS-1:0] OpenClose,
  output logic [NUM_PORTS-1:0] Moving,
  output logic [NUM_PORTS-1:0] Denied,
  output logic                 Busy
);

  localparam int CNT_W = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] closed;
  logic [NUM_PORTS-1:0] grant;
  logic [MAX_PORTS-1:0] open_req_pad;
  logic [MAX_PORTS-1:0] closed_pad;
  logic [MAX_PORTS-1:0] grant_pad;
  logic                 unused_grant_bits;

  // Widen to the arbiter width; absent ports look CLOSED and never request.
  always_comb begin
    open_req_pad                = '0;
    closed_pad                  = '1;
    open_req_pad[NUM_PORTS-1:0] = req & closed;
    closed_pad[NUM_PORTS-1:0]   = closed;
    grant_pad = grant_open(open_req_pad, closed_pad, INTERLOCK != 0);
  end

  assign grant             = grant_pad[NUM_PORTS-1:0];
  assign unused_grant_bits = ^grant_pad;
  assign Busy              = ~&closed;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      port_channel #(
        .TRAVEL_CYCLES(TRAVEL_CYCLES),
        .CNT_W        (CNT_W)
      ) u_channel (
        .clk       (Clock),
        .srst      (Reset),
        .flip      (SwitchFlip[gi]),
        .grant     (grant[gi]),
        .req       (req[gi]),
        .is_closed (closed[gi]),
        .open_state(OpenClose[gi]),
        .moving    (Moving[gi]),
        .denied    (Denied[gi])
      );
    end
  endgenerate

endmodule
